debounce_bank: RTL and testbench

DEBOUNCE_BANK -- requirements
Module: debounce_bank

---
 rtl/debounce_bank.sv | 160 ++++++++++++++++
 tb/tb_debounce_bank.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/debounce_bank.sv
`default_nettype none
// ============================================================================
// Module   : debounce_bank
// Brief    : N_CH-channel synchronizer + debouncer with rise/fall pulses.
//            Optional long-press detection via DEBOUNCE_BANK_LONGPRESS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module debounce_bank #(
    parameter int N_CH        = 4,
    parameter int DB_CYCLES   = 50_000_000,
    parameter int SYNC_STAGES = 2,
    parameter int LONG_CYCLES = 150_000_000
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [N_CH-1:0] signal_i,
    output logic [N_CH-1:0] level_o,
    output logic [N_CH-1:0] rise_o,
    output logic [N_CH-1:0] fall_o,
`ifdef DEBOUNCE_BANK_LONGPRESS_EN
    output logic [N_CH-1:0] long_o,
`endif
    output logic            any_event_o
);

    localparam int CNT_W = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] DB_MAX  = CNT_W'(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    localparam logic [0:0] ST_STABLE   = 1'b0;
    localparam logic [0:0] ST_CHANGING = 1'b1;

    logic [N_CH-1:0] rise_nx;
    logic [N_CH-1:0] fall_nx;
    logic            any_q;

`ifdef DEBOUNCE_BANK_LONGPRESS_EN
    localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

    logic [N_CH-1:0] long_nx;
`else
    // Long-press hardware is absent in this build; the parameter is only range-checked.
    if (LONG_CYCLES < 1) begin : g_long_cycles_unsupported
    end
`endif

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   sync_bit;
        logic [0:0]             state_q, state_d;
        logic [CNT_W-1:0]       cnt_q, cnt_d;
        logic                   level_q, level_d;
        logic                   rise_q, fall_q;

        assign sync_bit = sync_q[SYNC_STAGES-1];

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            level_d = level_q;
            case (state_q)
                ST_STABLE: begin
                    if (sync_bit != level_q) begin
                        state_d = ST_CHANGING;
                        cnt_d   = CNT_ONE;
                    end
                end
                ST_CHANGING: begin
                    if (sync_bit == level_q) begin
                        state_d = ST_STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q >= DB_MAX) begin
                        // Stable long enough: accept the new level.
                        level_d = ~level_q;
                        state_d = ST_STABLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end
            endcase
        end

        assign rise_nx[k] = level_d & ~level_q;
        assign fall_nx[k] = ~level_d & level_q;

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                sync_q  <= '0;
                state_q <= ST_STABLE;
                cnt_q   <= '0;
                level_q <= 1'b0;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
            end else begin
                sync_q  <= {sync_q[SYNC_STAGES-2:0], signal_i[k]};
                state_q <= state_d;
                cnt_q   <= cnt_d;
                level_q <= level_d;
                rise_q  <= rise_nx[k];
                fall_q  <= fall_nx[k];
            end
        end

        assign level_o[k] = level_q;
        assign rise_o[k]  = rise_q;
        assign fall_o[k]  = fall_q;

`ifdef DEBOUNCE_BANK_LONGPRESS_EN
        logic [HOLD_W-1:0] hold_q, hold_d;
        logic              long_q, long_d;

        // Hold counter saturates so each press yields at most one pulse.
        always_comb begin
            hold_d = '0;
            long_d = 1'b0;
            if (level_q) begin
                hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + HOLD_ONE;
                long_d = (hold_q == HOLD_LAST);
            end
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                hold_q <= '0;
                long_q <= 1'b0;
            end else begin
                hold_q <= hold_d;
                long_q <= long_d;
            end
        end

        assign long_o[k]  = long_q;
        assign long_nx[k] = long_d;
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            any_q <= 1'b0;
        end else begin
`ifdef DEBOUNCE_BANK_LONGPRESS_EN
            any_q <= (|rise_nx) | (|fall_nx) | (|long_nx);
`else
            any_q <= (|rise_nx) | (|fall_nx);
`endif
        end
    end

    assign any_event_o = any_q;

endmodule
`default_nettype wire

// File: tb/tb_debounce_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_debounce_bank
// Brief    : Directed + random bench for debounce_bank against a run-length model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_debounce_bank;

    localparam int N    = 4;
    localparam int DB   = 8;
    localparam int SS   = 2;
    localparam int LONG = 20;

    logic         clk = 1'b0;
    logic         rst_i = 1'b1;
    logic [N-1:0] signal_i = '0;
    logic [N-1:0] level_o, rise_o, fall_o;
    logic         any_event_o;
`ifdef DEBOUNCE_BANK_LONGPRESS_EN
    logic [N-1:0] long_o;
`endif

    debounce_bank #(
        .N_CH(N), .DB_CYCLES(DB), .SYNC_STAGES(SS), .LONG_CYCLES(LONG)
    ) dut (
        .clk_i(clk),
        .rst_i(rst_i),
        .signal_i(signal_i),
        .level_o(level_o),
        .rise_o(rise_o),
        .fall_o(fall_o),
`ifdef DEBOUNCE_BANK_LONGPRESS_EN
        .long_o(long_o),
`endif
        .any_event_o(any_event_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: raw samples delayed by SS edges; a level flips once the delayed
    // input has disagreed with it on DB+1 consecutive edges.
    logic [N-1:0] m_dly[$];
    int           m_run[N];
    int           m_age[N];
    logic [N-1:0] m_lvl, m_rise, m_fall, m_long;
    logic         m_any;

    task automatic model_edge(input logic [N-1:0] sig, input logic rst);
        logic [N-1:0] sv, prev;
        if (rst) begin
            m_dly.delete();
            for (int i = 0; i < SS; i++) m_dly.push_back('0);
            for (int k = 0; k < N; k++) begin m_run[k] = 0; m_age[k] = 0; end
            m_lvl = '0; m_rise = '0; m_fall = '0; m_long = '0; m_any = 1'b0;
        end else begin
            sv = m_dly.pop_front();
            m_dly.push_back(sig);
            prev = m_lvl;
            m_rise = '0; m_fall = '0; m_long = '0;
            for (int k = 0; k < N; k++) begin
                if (sv[k] != m_lvl[k]) begin
                    m_run[k]++;
                    if (m_run[k] == DB + 1) begin
                        m_lvl[k] = ~m_lvl[k];
                        m_run[k] = 0;
                        if (m_lvl[k]) m_rise[k] = 1'b1;
                        else          m_fall[k] = 1'b1;
                    end
                end else begin
                    m_run[k] = 0;
                end
                if (prev[k]) begin
                    if (m_age[k] < LONG) begin
                        m_age[k]++;
                        if (m_age[k] == LONG) m_long[k] = 1'b1;
                    end
                end else begin
                    m_age[k] = 0;
                end
            end
`ifdef DEBOUNCE_BANK_LONGPRESS_EN
            m_any = |{m_rise, m_fall, m_long};
`else
            m_any = |{m_rise, m_fall};
`endif
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input logic [N-1:0] sig, input logic rst);
        signal_i = sig;
        rst_i    = rst;
        @(posedge clk);
        model_edge(sig, rst);
        #1;
        check("level", 32'(level_o), 32'(m_lvl));
        check("rise",  32'(rise_o),  32'(m_rise));
        check("fall",  32'(fall_o),  32'(m_fall));
        check("any",   32'(any_event_o), 32'(m_any));
`ifdef DEBOUNCE_BANK_LONGPRESS_EN
        check("long",  32'(long_o),  32'(m_long));
`endif
    endtask

    initial begin
        logic [N-1:0] sig;
        int           rise_step, long_step, long_cnt;

        step('0, 1'b1);
        step('0, 1'b1);
        check("reset_level", 32'(level_o), 32'h0);
        check("reset_any",   32'(any_event_o), 32'h0);

        // Clean rise on channel 0: pulse exactly 10 edges after first sample.
        for (int i = 1; i <= 12; i++) begin
            step(4'b0001, 1'b0);
            check("rise_ch0", 32'(rise_o), (i == 11) ? 32'h1 : 32'h0);
        end
        check("level_ch0", 32'(level_o), 32'h1);

        // Seven-cycle glitch on channel 1 is rejected.
        for (int i = 1; i <= 7; i++) step(4'b0011, 1'b0);
        for (int i = 1; i <= 12; i++) begin
            step(4'b0001, 1'b0);
            check("glitch_any", 32'(any_event_o), 32'h0);
        end
        check("glitch_level", 32'(level_o), 32'h1);

        // Channels 3 and 2 rise in the same cycle.
        for (int i = 1; i <= 12; i++) begin
            step(4'b1101, 1'b0);
            check("rise_ch32", 32'(rise_o), (i == 11) ? 32'hC : 32'h0);
            check("any_ch32",  32'(any_event_o), (i == 11) ? 32'h1 : 32'h0);
        end

        // Channel 0 falls.
        for (int i = 1; i <= 12; i++) begin
            step(4'b1100, 1'b0);
            check("fall_ch0", 32'(fall_o), (i == 11) ? 32'h1 : 32'h0);
        end

        // Reset in the middle of a pending rise aborts it.
        for (int i = 1; i <= 5; i++) step(4'b1101, 1'b0);
        step(4'b0000, 1'b1);
        check("rst_mid_level", 32'(level_o), 32'h0);
        for (int i = 1; i <= 15; i++) begin
            step(4'b0000, 1'b0);
            check("rst_mid_rise", 32'(rise_o), 32'h0);
        end
        check("rst_mid_all", 32'({level_o, rise_o, fall_o, any_event_o}), 32'h0);

        // Input already high when reset releases.
        step(4'b1111, 1'b1);
        for (int i = 1; i <= 12; i++) begin
            step(4'b1111, 1'b0);
            check("post_rst_rise", 32'(rise_o), (i == 11) ? 32'hF : 32'h0);
        end

        // Random toggles with occasional glitches and resets.
        sig = 4'b1111;
        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < N; k++)
                if ($urandom_range(0, 15) == 0) sig[k] = ~sig[k];
            step(sig, ($urandom_range(0, 299) == 0));
        end

`ifdef DEBOUNCE_BANK_LONGPRESS_EN
        // Long press on channel 2: exactly one pulse 20 cycles after the rise.
        step('0, 1'b1);
        rise_step = -1; long_step = -1; long_cnt = 0;
        for (int i = 1; i <= 55; i++) begin
            step(4'b0100, 1'b0);
            if (rise_o[2]) rise_step = i;
            if (long_o[2]) begin long_step = i; long_cnt++; end
        end
        check("long_rise_step", 32'(rise_step), 32'd11);
        check("long_step",      32'(long_step), 32'd31);
        check("long_count",     32'(long_cnt),  32'd1);
`else
        rise_step = 0; long_step = 0; long_cnt = 0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
